// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: per-stage en/clear, PC enable, stall counter.
// Controls are combinational from registered state plus current hazards; memory waits freeze upstream stages.
module pipe_hazard_ctrl #(
   parameter int VEC_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic             Rs1UsedD,
   input  logic             Rs2UsedD,
   input  logic [4:0]       RdE,
   input  logic             MemToRegE,
   input  logic             BranchE,
   input  logic             VecStartE,
   input  logic             MemReqM,
   input  logic             MemAckM,
   output logic             PcEn,
   output logic             EnFD,
   output logic             ClrFD,
   output logic             EnDE,
   output logic             ClrDE,
   output logic             EnEM,
   output logic             ClrEM,
   output logic             EnMW,
   output logic             ClrMW,
   output logic [CNT_W-1:0] StallCycles
);

   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_VEC_BUSY} state_t;

   // Control word order: {PcEn, EnFD, ClrFD, EnDE, ClrDE, EnEM, ClrEM, EnMW, ClrMW}
   localparam logic [8:0] CTL_ADV = 9'b1_10_10_10_10;
   localparam logic [8:0] CTL_RST = 9'b0_11_11_11_11;
   localparam logic [8:0] CTL_MEM = 9'b0_00_00_00_11;
   localparam logic [8:0] CTL_VEC = 9'b0_00_00_11_10;
   localparam logic [8:0] CTL_BR  = 9'b1_11_11_10_10;
   localparam logic [8:0] CTL_LU  = 9'b0_00_11_10_10;

   localparam logic [4:0] VEC_INIT   = 5'(VEC_LAT - 1);
   localparam bit         VEC_STALLS = (VEC_LAT > 1);

   state_t           state_q, state_d;
   logic             ret_vec_q, ret_vec_d;
   logic [4:0]       vcnt_q, vcnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [8:0]       ctl;
   logic             mem_stall;
   logic             load_use;

   assign mem_stall = MemReqM && !MemAckM;
   assign load_use  = MemToRegE && (RdE != 5'd0) &&
                      ((Rs1UsedD && (Rs1D == RdE)) || (Rs2UsedD && (Rs2D == RdE)));

   always_comb begin
      state_d   = state_q;
      ret_vec_d = ret_vec_q;
      vcnt_d    = vcnt_q;
      ctl       = CTL_ADV;
      case (state_q)
         S_RUN: begin
            if (mem_stall) begin
               ctl       = CTL_MEM;
               state_d   = S_MEM_WAIT;
               ret_vec_d = 1'b0;
            end else if (VecStartE && VEC_STALLS) begin
               ctl     = CTL_VEC;
               vcnt_d  = VEC_INIT;
               state_d = S_VEC_BUSY;
            end else if (BranchE) begin
               ctl = CTL_BR;
            end else if (load_use) begin
               ctl = CTL_LU;
            end
         end
         S_VEC_BUSY: begin
            if (mem_stall) begin
               ctl       = CTL_MEM;
               state_d   = S_MEM_WAIT;
               ret_vec_d = 1'b1;
            end else if (vcnt_q == 5'd1) begin
               state_d = S_RUN;
            end else begin
               ctl    = CTL_VEC;
               vcnt_d = vcnt_q - 5'd1;
            end
         end
         S_MEM_WAIT: begin
            if (!MemAckM) begin
               ctl = CTL_MEM;
            end else begin
               // The ack cycle advances everything, so it also serves as the vector release cycle.
               state_d = (ret_vec_q && (vcnt_q != 5'd1)) ? S_VEC_BUSY : S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
      if (!rstn) begin
         ctl = CTL_RST;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!ctl[8] && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_RUN;
         ret_vec_q   <= 1'b0;
         vcnt_q      <= 5'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_vec_q   <= ret_vec_d;
         vcnt_q      <= vcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign {PcEn, EnFD, ClrFD, EnDE, ClrDE, EnEM, ClrEM, EnMW, ClrMW} = ctl;
   assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a VEC_LAT=4 instance and a VEC_LAT=1/3-bit-counter instance driven by the same stimulus.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic [4:0] Rs1D, Rs2D, RdE;
   logic       Rs1UsedD, Rs2UsedD, MemToRegE, BranchE, VecStartE, MemReqM, MemAckM;

   wire [8:0]  o4, o1;
   wire [15:0] cnt4;
   wire [2:0]  cnt1;

   int n_chk  = 0;
   int n_pass = 0;

   // {PcEn, EnFD, ClrFD, EnDE, ClrDE, EnEM, ClrEM, EnMW, ClrMW}
   localparam logic [8:0] ADV = 9'b1_10_10_10_10;
   localparam logic [8:0] RST = 9'b0_11_11_11_11;
   localparam logic [8:0] MEM = 9'b0_00_00_00_11;
   localparam logic [8:0] VEC = 9'b0_00_00_11_10;
   localparam logic [8:0] BR  = 9'b1_11_11_10_10;
   localparam logic [8:0] LU  = 9'b0_00_11_10_10;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.VEC_LAT(4), .CNT_W(16)) dut4 (
      .clk(clk), .rstn(rstn), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
      .RdE(RdE), .MemToRegE(MemToRegE), .BranchE(BranchE), .VecStartE(VecStartE),
      .MemReqM(MemReqM), .MemAckM(MemAckM),
      .PcEn(o4[8]), .EnFD(o4[7]), .ClrFD(o4[6]), .EnDE(o4[5]), .ClrDE(o4[4]),
      .EnEM(o4[3]), .ClrEM(o4[2]), .EnMW(o4[1]), .ClrMW(o4[0]), .StallCycles(cnt4));

   pipe_hazard_ctrl #(.VEC_LAT(1), .CNT_W(3)) dut1 (
      .clk(clk), .rstn(rstn), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1UsedD(Rs1UsedD), .Rs2UsedD(Rs2UsedD),
      .RdE(RdE), .MemToRegE(MemToRegE), .BranchE(BranchE), .VecStartE(VecStartE),
      .MemReqM(MemReqM), .MemAckM(MemAckM),
      .PcEn(o1[8]), .EnFD(o1[7]), .ClrFD(o1[6]), .EnDE(o1[5]), .ClrDE(o1[4]),
      .EnEM(o1[3]), .ClrEM(o1[2]), .EnMW(o1[1]), .ClrMW(o1[0]), .StallCycles(cnt1));

   always @(negedge clk) begin
      if (rstn === 1'b1)
         assert (!(BranchE && VecStartE)) else $error("FAIL illegal_branch_vec observed=1 expected=0");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Checks both instances' controls and counters mid-cycle, then crosses one rising edge.
   task automatic step(input string tag, input logic [8:0] e4, input logic [8:0] e1,
                       input logic [15:0] c4, input logic [2:0] c1);
      #2;
      chk({tag, "_ctl4"}, {7'd0, o4}, {7'd0, e4});
      chk({tag, "_ctl1"}, {7'd0, o1}, {7'd0, e1});
      chk({tag, "_cnt4"}, cnt4, c4);
      chk({tag, "_cnt1"}, {13'd0, cnt1}, {13'd0, c1});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      Rs1D = 5'd0; Rs2D = 5'd0; RdE = 5'd0;
      Rs1UsedD = 1'b0; Rs2UsedD = 1'b0; MemToRegE = 1'b0;
      BranchE = 1'b0; VecStartE = 1'b0; MemReqM = 1'b0; MemAckM = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      idle_in();
      @(posedge clk); #1;
      step("reset", RST, RST, 16'd0, 3'd0);
      rstn = 1'b1;
      step("idle", ADV, ADV, 16'd0, 3'd0);

      MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs1UsedD = 1'b1;
      step("loaduse_rs1", LU, LU, 16'd0, 3'd0);
      idle_in();
      step("after_loaduse", ADV, ADV, 16'd1, 3'd1);

      MemToRegE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs1UsedD = 1'b1;
      step("loaduse_x0", ADV, ADV, 16'd1, 3'd1);
      idle_in();
      MemToRegE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs2UsedD = 1'b0;
      step("rs2_unused", ADV, ADV, 16'd1, 3'd1);
      Rs2UsedD = 1'b1;
      step("loaduse_rs2", LU, LU, 16'd1, 3'd1);

      idle_in();
      MemToRegE = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs1UsedD = 1'b1; BranchE = 1'b1;
      step("branch_over_lu", BR, BR, 16'd2, 3'd2);

      idle_in();
      MemReqM = 1'b1;
      step("memwait1", MEM, MEM, 16'd2, 3'd2);
      step("memwait2", MEM, MEM, 16'd3, 3'd3);
      step("memwait3", MEM, MEM, 16'd4, 3'd4);
      MemAckM = 1'b1;
      step("mem_ack", ADV, ADV, 16'd5, 3'd5);
      step("req_ack_same", ADV, ADV, 16'd5, 3'd5);

      idle_in();
      VecStartE = 1'b1;
      step("vec1", VEC, ADV, 16'd5, 3'd5);
      step("vec2", VEC, ADV, 16'd6, 3'd5);
      step("vec3", VEC, ADV, 16'd7, 3'd5);
      step("vec_release", ADV, ADV, 16'd8, 3'd5);

      step("vecb_entry", VEC, ADV, 16'd8, 3'd5);
      VecStartE = 1'b0;
      step("vecb_busy", VEC, ADV, 16'd9, 3'd5);
      MemReqM = 1'b1;
      step("vecb_mem1", MEM, MEM, 16'd10, 3'd5);
      step("vecb_mem2", MEM, MEM, 16'd11, 3'd6);
      MemAckM = 1'b1;
      step("vecb_ack", ADV, ADV, 16'd12, 3'd7);
      idle_in();
      BranchE = 1'b1;
      step("vecb_resume", VEC, BR, 16'd12, 3'd7);
      BranchE = 1'b0;
      step("vecb_release", ADV, ADV, 16'd13, 3'd7);
      step("vecb_run", ADV, ADV, 16'd13, 3'd7);

      MemReqM = 1'b1;
      step("pre_rst_mem", MEM, MEM, 16'd13, 3'd7);
      chk("sat_cnt1", {13'd0, cnt1}, 16'd7);
      chk("pre_rst_cnt4", cnt4, 16'd14);
      rstn = 1'b0;
      step("rst_async", RST, RST, 16'd0, 3'd0);
      step("rst_hold", RST, RST, 16'd0, 3'd0);
      idle_in();
      rstn = 1'b1;
      step("post_rst", ADV, ADV, 16'd0, 3'd0);
      step("post_rst2", ADV, ADV, 16'd0, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the five-stage RISC-V pipeline. It drives the en/clear pair of every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. Its inputs are load-use hazards, taken branches/jumps, the data-RAM request/acknowledge handshake and multi-cycle vector ops in EX. It holds a small FSM for memory waits and vector occupancy, plus a saturating stall-cycle counter.

Parameters:
VEC_LAT, 4, number of cycles a vector op occupies EX (legal range 1..16)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
Rs1D  in  5  rs1 of instruction in ID
Rs2D  in  5  rs2 of instruction in ID
Rs1UsedD  in  1  ID instruction reads rs1
Rs2UsedD  in  1  ID instruction reads rs2
RdE  in  5  destination of instruction in EX
MemToRegE  in  1  EX instruction is a load
BranchE  in  1  EX redirects PC (taken branch/jump)
VecStartE  in  1  EX holds a vector op
MemReqM  in  1  MEM stage issues data-RAM access
MemAckM  in  1  data RAM completes access this cycle
PcEn  out  1  PC register enable
EnFD, ClrFD  out  1,1  IF/ID enable, clear
EnDE, ClrDE  out  1,1  ID/EX enable, clear
EnEM, ClrEM  out  1,1  EX/MEM enable, clear
EnMW, ClrMW  out  1,1  MEM/WB enable, clear
StallCycles  out  CNT_W  saturating count of cycles with PcEn=0

Behaviour:
- Outputs are combinational from the registered state and current inputs. State, vector counter and StallCycles are registered.
- "Advance" means En=1, Clr=0. "Freeze" means En=0. "Bubble" means En=1, Clr=1.
- Reset (rstn=0, asynchronous): state=RUN, vcnt=0, StallCycles=0. While rstn=0 all En=1, all Clr=1, PcEn=0, which flushes every stage.
- States: RUN, MEM_WAIT, VEC_BUSY. Priority within a cycle: mem stall > vector > branch > load-use.
- Mem stall is active when MemReqM=1 and MemAckM=0.
  - Effect: PcEn=0; FD, DE, EM frozen; MW bubble, so WB never double-writes.
  - From RUN or VEC_BUSY, the FSM goes to MEM_WAIT and remembers the return state (RUN or VEC_BUSY).
  - vcnt holds during the stall.
  - A req and ack in the same cycle causes no stall.
- MEM_WAIT: identical freeze each cycle while MemAckM=0. The cycle MemAckM=1, all stages advance, and the FSM returns to the remembered state (or to RUN if that state's release condition is met, see VEC_BUSY).
- Vector, in RUN with VecStartE=1 and VEC_LAT>1:
  - PcEn=0; FD and DE frozen; EM bubble; MW advance.
  - vcnt <= VEC_LAT-1; FSM goes to VEC_BUSY.
- VEC_BUSY (VecStartE ignored):
  - If vcnt==1: release, i.e. all advance, PcEn=1, FSM goes to RUN.
  - Otherwise: same stall pattern as entry, and vcnt decrements.
  - Net effect: the op resides in EX for exactly VEC_LAT cycles (VEC_LAT-1 stall cycles). VEC_LAT=1 gives no stall.
- Branch, RUN only: PcEn=1, FD bubble, DE bubble, EM and MW advance. A branch overrides load-use, because the dependent instruction is flushed anyway.
- Load-use, RUN only: active when MemToRegE=1, RdE!=0, and (Rs1UsedD and Rs1D==RdE) or (Rs2UsedD and Rs2D==RdE). Effect: PcEn=0, FD frozen, DE bubble, EM and MW advance, for exactly one cycle.
- No hazard: all advance, PcEn=1.
- StallCycles increments each cycle PcEn=0 while rstn=1, and saturates at all-ones.
- BranchE and VecStartE both high is illegal; the bench asserts it never occurs.
- RdE=x0 never triggers load-use.

Test Plan:
- Load-use: MemToRegE=1, RdE=5, Rs1D=5, Rs1UsedD=1 -> one cycle PcEn=0, EnFD=0, EnDE=1/ClrDE=1; next cycle all advance; StallCycles=1.
- Branch plus load-use in the same cycle: BranchE=1 with the hazard above -> PcEn=1, ClrFD=1, ClrDE=1, no freeze; StallCycles unchanged.
- Memory wait: MemReqM=1, MemAckM=0 for 3 cycles, then ack -> 3 cycles with EnFD/EnDE/EnEM=0 and EnMW=1/ClrMW=1; all advance on the ack cycle; StallCycles=3.
- Vector VEC_LAT=4: VecStartE held high -> 3 cycles of EM bubble with PcEn=0, release on the 4th; repeat with VEC_LAT=1 -> no stall.
- Mem stall inside VEC_BUSY (vcnt=2): 2 wait cycles, then ack -> return to VEC_BUSY with vcnt still 2; release 2 cycles later.
- Reset mid-operation: drop rstn during MEM_WAIT -> immediately all Clr=1, PcEn=0; after release, state=RUN and StallCycles=0.
